// File: rtl/radix2_div_core.sv
// Iterative radix-2 restoring divider (DIV/DIVU) with start/ready/annul handshake.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes in one cycle with a zero result.
module radix2_div_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t               r_state, w_state_next;
  logic [CW-1:0]        r_cnt, w_cnt_next;
  logic                 r_signed, w_signed_next;
  logic                 r_sign_q, w_sign_q_next;
  logic                 r_sign_r, w_sign_r_next;
  logic [WIDTH-1:0]     r_divisor, w_divisor_next;
  logic [WIDTH-1:0]     r_rem, w_rem_next;
  logic [WIDTH-1:0]     r_quo, w_quo_next;
  logic [2*WIDTH-1:0]   r_result, w_result_next;
  logic                 r_ready, w_ready_next;

  logic                 w_accept;
  logic                 w_op1_neg, w_op2_neg;
  logic [WIDTH-1:0]     w_op1_mag, w_op2_mag;
  logic                 w_last;
  logic [WIDTH:0]       w_shift;
  logic                 w_trial_ok;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH-1:0]     w_fix_quo, w_fix_rem;

  assign w_accept  = start_i && !annul_i;
  assign w_op1_neg = signed_div_i && opdata1_i[WIDTH-1];
  assign w_op2_neg = signed_div_i && opdata2_i[WIDTH-1];
  assign w_op1_mag = w_op1_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign w_op2_mag = w_op2_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
  assign w_last    = (r_cnt == CW'(WIDTH));

  // One restoring step: {R,Q} << 1, subtract divisor if it fits.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial_ok = (w_shift >= {1'b0, r_divisor});
  assign w_diff     = w_shift[WIDTH-1:0] - r_divisor;

  assign w_fix_quo = (r_signed && r_sign_q) ? (~r_quo + WIDTH'(1)) : r_quo;
  assign w_fix_rem = (r_signed && r_sign_r) ? (~r_rem + WIDTH'(1)) : r_rem;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
          w_state_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
`else
          w_state_next = S_ON;
`endif
        end
      end
      S_BYZERO: w_state_next = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)     w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_END;
      end
      S_END:    if (!start_i) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_cnt_next     = r_cnt;
    w_signed_next  = r_signed;
    w_sign_q_next  = r_sign_q;
    w_sign_r_next  = r_sign_r;
    w_divisor_next = r_divisor;
    w_rem_next     = r_rem;
    w_quo_next     = r_quo;
    w_result_next  = r_result;
    w_ready_next   = r_ready;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_signed_next  = signed_div_i;
          w_sign_q_next  = w_op1_neg ^ w_op2_neg;
          w_sign_r_next  = w_op1_neg;
          w_divisor_next = w_op2_mag;
          w_rem_next     = '0;
          w_quo_next     = w_op1_mag;
          w_cnt_next     = '0;
        end
      end
      S_BYZERO: begin
        if (!annul_i) begin
          w_result_next = '0;
          w_ready_next  = 1'b1;
        end
      end
      S_ON: begin
        if (!annul_i) begin
          if (!w_last) begin
            w_rem_next = w_trial_ok ? w_diff : w_shift[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], w_trial_ok};
            w_cnt_next = r_cnt + CW'(1);
          end else begin
            w_result_next = {w_fix_rem, w_fix_quo};
            w_ready_next  = 1'b1;
          end
        end
      end
      S_END: begin
        if (!start_i) begin
          w_result_next = '0;
          w_ready_next  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_signed  <= w_signed_next;
      r_sign_q  <= w_sign_q_next;
      r_sign_r  <= w_sign_r_next;
      r_divisor <= w_divisor_next;
      r_rem     <= w_rem_next;
      r_quo     <= w_quo_next;
      r_result  <= w_result_next;
      r_ready   <= w_ready_next;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_radix2_div_core.sv
// Scoreboard bench for radix2_div_core: driver pushes expected result and arrival cycle,
// a negedge monitor pops and compares on each rising ready_o.
module tb_radix2_div_core;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    int          due;
    int          id;
  } exp_t;

  exp_t sb[$];

  radix2_div_core #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare on each rising edge of ready_o
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (ready_o && !prev_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ready: result=%h at cycle %0d, no request pending", result_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        tests++;
        if (result_o !== e.res) begin
          fails++;
          $display("FAIL result[%0d]: got %h expected %h", e.id, result_o, e.res);
        end else
          $display("[TB] div %0d result %h ok", e.id, result_o);
        tests++;
        if (cyc != e.due) begin
          fails++;
          $display("FAIL latency[%0d]: ready at cycle %0d expected %0d", e.id, cyc, e.due);
        end
      end
    end
    prev_ready = ready_o;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end else
      $display("[TB] %s ok (%h)", name, got);
  endtask

  // Issue one divide, hold start until ready, then either drop start or reset in END.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input int lat, input int id,
                         input bit reset_in_end);
    exp_t e;
    int n;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    e.res = exp_res;
    e.due = cyc + 1 + lat;
    e.id  = id;
    sb.push_back(e);
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      tests++; fails++;
      $display("FAIL timeout[%0d]: ready_o=%b after %0d cycles, required 1", id, ready_o, n);
    end
    if (reset_in_end) begin
      resetn = 1'b0;
      #1;
      check($sformatf("async_reset_end_ready[%0d]", id), {63'd0, ready_o}, 64'd0);
      check($sformatf("async_reset_end_result[%0d]", id), result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
    end else begin
      start_i = 1'b0;
      @(negedge clk);
      check($sformatf("drop_ready[%0d]", id), {63'd0, ready_o}, 64'd0);
      check($sformatf("drop_result[%0d]", id), result_o, 64'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ready_seen;
    repeat (3) @(negedge clk);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {63'd0, ready_o}, 64'd0);

    run_div(1'b0, 32'd100,       32'd7,          {32'h00000002, 32'h0000000E}, 33, 1, 1'b0);
    run_div(1'b1, 32'hFFFFFFF9,  32'h00000002,   {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 2, 1'b0);
    run_div(1'b1, 32'h00000007,  32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 33, 3, 1'b0);
    run_div(1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 33, 4, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF,  32'h00000001,   {32'h00000000, 32'hFFFFFFFF}, 33, 5, 1'b0);
`ifdef DIV_ZERO_FAST_EN
    run_div(1'b0, 32'h12345678,  32'h00000000,   64'd0, 1, 6, 1'b0);
    run_div(1'b1, 32'hFFFFFF9C,  32'h00000000,   64'd0, 1, 7, 1'b0);
`else
    run_div(1'b0, 32'h12345678,  32'h00000000,   {32'h12345678, 32'hFFFFFFFF}, 33, 6, 1'b0);
    run_div(1'b1, 32'hFFFFFF9C,  32'h00000000,   {32'hFFFFFF9C, 32'h00000001}, 33, 7, 1'b0);
`endif

    // Annul 10 edges after acceptance; no result may appear
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    ready_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) ready_seen = 1'b1;
    end
    check("annul_no_ready", {63'd0, ready_seen}, 64'd0);
    run_div(1'b0, 32'd9, 32'd3, {32'h00000000, 32'h00000003}, 33, 8, 1'b0);

    // Reset mid-iteration, then a clean divide
    signed_div_i = 1'b1; opdata1_i = 32'hFFFFFF9C; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_reset_ready", {63'd0, ready_o}, 64'd0);
    check("mid_reset_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 9, 1'b0);

    // Asynchronous reset while a result is being held
    run_div(1'b0, 32'd1000, 32'd10, {32'h00000000, 32'h00000064}, 33, 10, 1'b1);
    run_div(1'b0, 32'd1001, 32'd10, {32'h00000001, 32'h00000064}, 33, 11, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
